ipb_segment_arbiter: RTL and testbench
======================================

IPB_SEGMENT_ARBITER -- requirements
Module: ipb_segment_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: max READ-state cycles awaiting segment ack (legal range 2..4095).
REQ-002 SHALL have parameter SEG_MASK, default 4'b0001: bit n=1 means segment n (ipb_addr[31:28]=4'b0100+n) is populated.
REQ-003 SHALL have port ipb_clk  in  1  single clock; all logic on rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high.
REQ-005 SHALL have port ipb_strobe  in  1  IPbus transaction request, held by master until ack/err.
REQ-006 SHALL have port ipb_addr  in  32  IPbus address.
REQ-007 SHALL have port ipb_write  in  1  1=write, 0=read.
REQ-008 SHALL have port ipb_wdata  in  32  write data.
REQ-009 SHALL have port ipb_rdata  out  32  read data returned to IPbus.
REQ-010 SHALL have port ipb_ack  out  1  one-cycle transaction-complete pulse.
REQ-011 SHALL have port ipb_err  out  1  one-cycle transaction-failed pulse.
REQ-012 SHALL have port seg_sel  out  4  one-hot selected segment, held for whole transaction.
REQ-013 SHALL have port io_addr  out  28  latched ipb_addr[27:0].
REQ-014 SHALL have port io_wr_data  out  32  latched ipb_wdata.
REQ-015 SHALL have port io_sync  out  1  operation in progress toward segment.
REQ-016 SHALL have port io_rd_en  out  1  read enable, held until segment ack or timeout.
REQ-017 SHALL have port io_wr_en  out  1  one-cycle write enable.
REQ-018 SHALL have port seg_rd_data  in  128  segment n read data on bits [32n+31:32n].
REQ-019 SHALL have port seg_rd_ack  in  4  per-segment read-data-valid.
REQ-020 SHALL have port err_count  out  16  saturating count of ipb_err pulses.

Function
REQ-021 SHALL implement states IDLE, WRITE, READ, ACK, ERR, HOLD.
REQ-022 IDLE with ipb_strobe=1 SHALL latch address, wdata, write flag and decoded seg_sel at that edge.
REQ-023 IDLE decode: ipb_addr[31:30]!=2'b01 or SEG_MASK bit for ipb_addr[29:28] clear -> ERR; else write -> WRITE, read -> READ.
REQ-024 WRITE SHALL last one cycle with io_sync=1, io_wr_en=1, then -> ACK.
REQ-025 READ SHALL drive io_sync=1, io_rd_en=1; cycle counter cleared on entry, +1 per READ cycle.
REQ-026 In READ, seg_rd_ack bit of selected segment=1 SHALL capture that segment's seg_rd_data into ipb_rdata and -> ACK.
REQ-027 In READ, no ack by the TIMEOUT-th READ cycle SHALL -> ERR; ack on that final cycle takes precedence over timeout.
REQ-028 seg_rd_ack bits of non-selected segments SHALL be ignored in all states.
REQ-029 ACK SHALL assert ipb_ack=1 for one cycle, then -> HOLD; ERR SHALL assert ipb_err=1 for one cycle, increment err_count (saturate at 16'hFFFF), then -> HOLD.
REQ-030 HOLD SHALL keep io_sync/io_rd_en/io_wr_en=0 and -> IDLE when ipb_strobe=0; a strobe still high SHALL NOT start a new transaction.
REQ-031 Latency: write ack 2 cycles after strobe sampled in IDLE; read ack 1 cycle after segment ack sampled; ipb_ack and ipb_err never both 1.
REQ-032 ipb_rdata SHALL change only on successful read capture; errors and writes leave it unchanged.
REQ-033 seg_sel SHALL be 4'b0000 in IDLE, HOLD and for ERR from decode failure; io_addr/io_wr_data hold last latched value.

Reset
REQ-034 reset=1 SHALL, at the next edge, force IDLE and zero ipb_rdata, ipb_ack, ipb_err, seg_sel, io_addr, io_wr_data, io_sync, io_rd_en, io_wr_en, err_count, timeout counter.
REQ-035 reset mid-transaction SHALL abandon it with no ack/err pulse; strobe still high after reset release SHALL be treated as a new request.

Verification
REQ-036 Write addr 0x4000_0010 data 0xA5A5_0001 -> seg_sel=0001, io_addr=0x000_0010, io_wr_en 1 cycle, ipb_ack 2 cycles after strobe sample.
REQ-037 Read addr 0x4000_0004, segment 0 acks 3 cycles into READ with 0x1234_5678 -> ipb_rdata=0x1234_5678, ipb_ack next cycle.
REQ-038 Read addr 0x5000_0000 with SEG_MASK=0001 -> ipb_err 1 cycle after strobe sample, err_count=1, io_sync never 1.
REQ-039 TIMEOUT=4, read segment 0 never acks (segment 1 acks) -> io_rd_en high 4 cycles, ipb_err, ipb_rdata unchanged; repeat with ack on 4th cycle -> ipb_ack.
REQ-040 Strobe held high after ack -> no second transaction until strobe low; reset asserted during READ -> all outputs 0 next edge, no ack.
REQ-041 Force 65536 errors -> err_count stays 16'hFFFF.

Source files
------------

// File: rtl/ipb_segment_arbiter.sv
// IPbus slave that decodes ipb_addr[31:28] onto one of four I/O segments and runs a
// single read or write toward it. Write acks 2 cycles after the strobe is sampled;
// read acks 1 cycle after the segment ack, or errors after TIMEOUT READ cycles.
// Backpressure: the master holds ipb_strobe until ack/err. The next transaction is
// accepted only after the strobe has been seen low in HOLD.
//
// Ports:
//   ipb_clk, reset                 clock, synchronous active-high reset
//   ipb_strobe/addr/write/wdata    IPbus request from the master
//   ipb_rdata/ack/err              IPbus response (ack/err are one-cycle pulses)
//   seg_sel                        one-hot selected segment, zero outside a live transaction
//   io_addr/io_wr_data             latched address[27:0] and write data
//   io_sync/io_rd_en/io_wr_en      segment strobes
//   seg_rd_data/seg_rd_ack         per-segment read return, 32 bits and 1 valid per segment
//   err_count                      saturating count of ipb_err pulses
module ipb_segment_arbiter #(
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [3:0]  SEG_MASK = 4'b0001
) (
  input  logic         ipb_clk,
  input  logic         reset,
  input  logic         ipb_strobe,
  input  logic [31:0]  ipb_addr,
  input  logic         ipb_write,
  input  logic [31:0]  ipb_wdata,
  output logic [31:0]  ipb_rdata,
  output logic         ipb_ack,
  output logic         ipb_err,
  output logic [3:0]   seg_sel,
  output logic [27:0]  io_addr,
  output logic [31:0]  io_wr_data,
  output logic         io_sync,
  output logic         io_rd_en,
  output logic         io_wr_en,
  input  logic [127:0] seg_rd_data,
  input  logic [3:0]   seg_rd_ack,
  output logic [15:0]  err_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_ACK,
    S_ERR,
    S_HOLD
  } state_e;

  // Counter value seen during the final permitted READ cycle.
  localparam logic [11:0] TO_LAST = 12'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [3:0]  seg_q, seg_d;
  logic [27:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [11:0] cnt_q, cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;

  // Address decode, evaluated only while IDLE.
  logic [1:0]  dec_idx;
  logic        dec_ok;
  logic [3:0]  dec_onehot;

  assign dec_idx    = ipb_addr[29:28];
  assign dec_ok     = (ipb_addr[31:30] == 2'b01) && SEG_MASK[dec_idx];
  assign dec_onehot = 4'b0001 << dec_idx;

  // Only the selected segment's ack and data lane matter. seg_q is one-hot or zero,
  // so masking keeps acks from other segments out.
  logic        sel_ack;
  logic [31:0] sel_data;

  assign sel_ack = |(seg_rd_ack & seg_q);

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < 4; i++) begin
      if (seg_q[i]) begin
        sel_data = sel_data | seg_rd_data[32*i +: 32];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    seg_d     = seg_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    cnt_d     = cnt_q;
    err_cnt_d = err_cnt_q;
    io_sync   = 1'b0;
    io_rd_en  = 1'b0;
    io_wr_en  = 1'b0;
    ipb_ack   = 1'b0;
    ipb_err   = 1'b0;
    seg_sel   = 4'b0000;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (ipb_strobe) begin
          addr_d  = ipb_addr[27:0];
          wdata_d = ipb_wdata;
          // The write flag is captured by the choice between WRITE and READ.
          if (dec_ok) begin
            seg_d   = dec_onehot;
            state_d = ipb_write ? S_WRITE : S_READ;
          end else begin
            seg_d   = 4'b0000;
            state_d = S_ERR;
          end
        end
      end

      S_WRITE: begin
        io_sync  = 1'b1;
        io_wr_en = 1'b1;
        seg_sel  = seg_q;
        state_d  = S_ACK;
      end

      S_READ: begin
        io_sync  = 1'b1;
        io_rd_en = 1'b1;
        seg_sel  = seg_q;
        cnt_d    = cnt_q + 12'd1;
        // An ack on the last permitted cycle wins over the timeout.
        if (sel_ack) begin
          rdata_d = sel_data;
          state_d = S_ACK;
        end else if (cnt_q == TO_LAST) begin
          state_d = S_ERR;
        end
      end

      S_ACK: begin
        ipb_ack = 1'b1;
        seg_sel = seg_q;
        state_d = S_HOLD;
      end

      S_ERR: begin
        ipb_err = 1'b1;
        seg_sel = seg_q;
        if (err_cnt_q != 16'hFFFF) begin
          err_cnt_d = err_cnt_q + 16'd1;
        end
        state_d = S_HOLD;
      end

      S_HOLD: begin
        // Wait for the master to drop its strobe so one request yields one response.
        if (!ipb_strobe) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ipb_clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      seg_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      cnt_q     <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      seg_q     <= seg_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      cnt_q     <= cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign ipb_rdata  = rdata_q;
  assign io_addr    = addr_q;
  assign io_wr_data = wdata_q;
  assign err_count  = err_cnt_q;

endmodule

// File: tb/tb_ipb_segment_arbiter.sv
// Self-checking bench for ipb_segment_arbiter. It runs directed and random IPbus
// transactions and checks them against a transaction-level outcome model.
// The DUT is built with TIMEOUT=4 and SEG_MASK=4'b0101, so segments 0 and 2 are populated.
module tb_ipb_segment_arbiter;

  localparam int unsigned TO   = 4;
  localparam logic [3:0]  MASK = 4'b0101;

  logic         ipb_clk = 1'b0;
  logic         reset;
  logic         ipb_strobe;
  logic [31:0]  ipb_addr;
  logic         ipb_write;
  logic [31:0]  ipb_wdata;
  logic [31:0]  ipb_rdata;
  logic         ipb_ack;
  logic         ipb_err;
  logic [3:0]   seg_sel;
  logic [27:0]  io_addr;
  logic [31:0]  io_wr_data;
  logic         io_sync;
  logic         io_rd_en;
  logic         io_wr_en;
  logic [127:0] seg_rd_data;
  logic [3:0]   seg_rd_ack;
  logic [15:0]  err_count;

  ipb_segment_arbiter #(.TIMEOUT(TO), .SEG_MASK(MASK)) dut (
    .ipb_clk    (ipb_clk),
    .reset      (reset),
    .ipb_strobe (ipb_strobe),
    .ipb_addr   (ipb_addr),
    .ipb_write  (ipb_write),
    .ipb_wdata  (ipb_wdata),
    .ipb_rdata  (ipb_rdata),
    .ipb_ack    (ipb_ack),
    .ipb_err    (ipb_err),
    .seg_sel    (seg_sel),
    .io_addr    (io_addr),
    .io_wr_data (io_wr_data),
    .io_sync    (io_sync),
    .io_rd_en   (io_rd_en),
    .io_wr_en   (io_wr_en),
    .seg_rd_data(seg_rd_data),
    .seg_rd_ack (seg_rd_ack),
    .err_count  (err_count)
  );

  always #5 ipb_clk = ~ipb_clk;

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [31:0] model_rdata = '0;
  logic [15:0] model_err   = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Run one complete IPbus transaction starting from IDLE, just after a rising edge.
  // ack_at: READ cycle (1-based) on which the selected segment acks; 0 means never.
  // noise:  acks forced onto non-selected segments on every cycle.
  task automatic run_txn(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                         input int ack_at, input logic [31:0] ack_data,
                         input logic [3:0] noise, input int hold_extra);
    logic       ok;
    int         idx;
    logic [3:0] exp_sel;
    logic       exp_ack;
    int         exp_cyc, exp_rd, exp_wr, exp_sync;
    int         cyc, rd_n, wr_n, sync_n, done_cyc;
    logic       done, got_ack;

    // Outcome derived directly from the decode, timeout and latency rules.
    idx     = int'(addr[29:28]);
    ok      = (addr[31:30] == 2'b01) && MASK[idx];
    exp_sel = ok ? (4'b0001 << idx) : 4'b0000;
    if (!ok) begin
      exp_ack = 0; exp_cyc = 1; exp_rd = 0; exp_wr = 0; exp_sync = 0;
    end else if (wr) begin
      exp_ack = 1; exp_cyc = 2; exp_rd = 0; exp_wr = 1; exp_sync = 1;
    end else if (ack_at >= 1 && ack_at <= int'(TO)) begin
      exp_ack = 1; exp_cyc = ack_at + 1; exp_rd = ack_at; exp_wr = 0; exp_sync = ack_at;
    end else begin
      exp_ack = 0; exp_cyc = int'(TO) + 1; exp_rd = int'(TO); exp_wr = 0; exp_sync = int'(TO);
    end
    if (exp_ack && !wr) model_rdata = ack_data;
    if (!exp_ack && model_err != 16'hFFFF) model_err = model_err + 16'd1;

    ipb_addr   = addr;
    ipb_write  = wr;
    ipb_wdata  = wd;
    ipb_strobe = 1'b1;
    @(posedge ipb_clk);
    cyc = 0; rd_n = 0; wr_n = 0; sync_n = 0; done = 0; got_ack = 0; done_cyc = 0;
    while (!done && cyc < 40) begin
      @(negedge ipb_clk);
      cyc++;
      chk("ack_err_exclusive", {31'b0, ipb_ack & ipb_err}, 32'd0);
      chk("seg_sel_in_txn", {28'b0, seg_sel}, {28'b0, exp_sel});
      if (cyc == 1) begin
        chk("io_addr_latched", {4'b0, io_addr}, {4'b0, addr[27:0]});
        chk("io_wr_data_latched", io_wr_data, wd);
      end
      rd_n   += int'(io_rd_en);
      wr_n   += int'(io_wr_en);
      sync_n += int'(io_sync);
      if (ipb_ack || ipb_err) begin
        done = 1; got_ack = ipb_ack; done_cyc = cyc;
      end
      seg_rd_data = rand128();
      seg_rd_ack  = (4'($urandom) | noise) & ~exp_sel;
      if (io_rd_en && rd_n == ack_at) begin
        seg_rd_ack = seg_rd_ack | exp_sel;
        seg_rd_data[32*idx +: 32] = ack_data;
      end
      if (!done) @(posedge ipb_clk);
    end
    chk("txn_completed", {31'b0, done}, 32'd1);
    chk("outcome_is_ack", {31'b0, got_ack}, {31'b0, exp_ack});
    chk("response_cycle", done_cyc, exp_cyc);
    chk("io_rd_en_cycles", rd_n, exp_rd);
    chk("io_wr_en_cycles", wr_n, exp_wr);
    chk("io_sync_cycles", sync_n, exp_sync);
    chk("ipb_rdata_at_resp", ipb_rdata, model_rdata);
    seg_rd_ack = '0;

    // Strobe stays high through HOLD, so no new transaction may start.
    for (int h = 0; h <= hold_extra; h++) begin
      @(posedge ipb_clk);
      @(negedge ipb_clk);
      chk("hold_quiet", {27'b0, io_sync, io_rd_en, io_wr_en, ipb_ack, ipb_err}, 32'd0);
      chk("hold_seg_sel", {28'b0, seg_sel}, 32'd0);
      chk("err_count", {16'b0, err_count}, {16'b0, model_err});
      chk("ipb_rdata_hold", ipb_rdata, model_rdata);
    end
    ipb_strobe = 1'b0;
    @(posedge ipb_clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int          r;

    reset = 1'b1; ipb_strobe = 0; ipb_addr = '0; ipb_write = 0; ipb_wdata = '0;
    seg_rd_data = '0; seg_rd_ack = '0;
    repeat (3) @(posedge ipb_clk);
    @(negedge ipb_clk);
    chk("reset_ctrl", {27'b0, io_sync, io_rd_en, io_wr_en, ipb_ack, ipb_err}, 32'd0);
    chk("reset_seg_sel", {28'b0, seg_sel}, 32'd0);
    chk("reset_rdata", ipb_rdata, 32'd0);
    chk("reset_err_count", {16'b0, err_count}, 32'd0);
    chk("reset_io_addr", {4'b0, io_addr}, 32'd0);
    reset = 1'b0;
    @(posedge ipb_clk);
    #1;

    // Directed cases.
    run_txn(32'h4000_0010, 1'b1, 32'hA5A5_0001, 0, 32'h0, 4'b0000, 0);
    run_txn(32'h4000_0004, 1'b0, 32'h0, 3, 32'h1234_5678, 4'b0000, 1);
    run_txn(32'h5000_0000, 1'b0, 32'h0, 1, 32'hDEAD_BEEF, 4'b0000, 0);
    run_txn(32'h4000_0008, 1'b0, 32'h0, 0, 32'h0, 4'b0010, 0);
    run_txn(32'h4000_000C, 1'b0, 32'h0, 4, 32'hCAFE_F00D, 4'b0010, 0);
    run_txn(32'h4000_000C, 1'b0, 32'h0, 5, 32'h0BAD_0BAD, 4'b1110, 0);
    run_txn(32'h6123_4567, 1'b1, 32'h0000_5555, 0, 32'h0, 4'b0000, 3);
    run_txn(32'h8000_0000, 1'b1, 32'h1111_2222, 0, 32'h0, 4'b1111, 0);
    run_txn(32'h6000_0040, 1'b0, 32'h0, 1, 32'h7777_8888, 4'b1011, 0);

    // Random transactions.
    for (int k = 0; k < 80; k++) begin
      r = $urandom_range(0, 5);
      a = $urandom;
      if (r < 4) a[31:28] = {2'b01, 2'(r)};
      run_txn(a, 1'($urandom), $urandom, $urandom_range(0, 6), $urandom,
              4'($urandom), $urandom_range(0, 2));
    end

    // Saturation: preload the counter near its ceiling in place of 65533 earlier errors.
    force dut.err_cnt_q = 16'hFFFD;
    #1;
    release dut.err_cnt_q;
    model_err = 16'hFFFD;
    for (int k = 0; k < 4; k++) begin
      run_txn(32'h0000_0000 | (k << 4), 1'b0, 32'h0, 1, 32'h0, 4'b0000, 0);
    end

    // Reset during READ abandons the transaction. A strobe that is still high then restarts it.
    ipb_addr = 32'h4000_0100; ipb_write = 1'b0; ipb_wdata = 32'h3C3C_3C3C; ipb_strobe = 1'b1;
    @(posedge ipb_clk);
    @(negedge ipb_clk);
    chk("rst_pre_read", {31'b0, io_rd_en}, 32'd1);
    @(posedge ipb_clk);
    @(negedge ipb_clk);
    reset = 1'b1;
    @(posedge ipb_clk);
    @(negedge ipb_clk);
    chk("rst_mid_ctrl", {27'b0, io_sync, io_rd_en, io_wr_en, ipb_ack, ipb_err}, 32'd0);
    chk("rst_mid_seg_sel", {28'b0, seg_sel}, 32'd0);
    chk("rst_mid_io_addr", {4'b0, io_addr}, 32'd0);
    chk("rst_mid_io_wr_data", io_wr_data, 32'd0);
    chk("rst_mid_rdata", ipb_rdata, 32'd0);
    chk("rst_mid_err_count", {16'b0, err_count}, 32'd0);
    reset = 1'b0;
    model_rdata = '0;
    model_err   = '0;
    @(posedge ipb_clk);
    @(negedge ipb_clk);
    chk("rst_restart_read", {31'b0, io_rd_en}, 32'd1);
    seg_rd_ack = 4'b0001;
    seg_rd_data[31:0] = 32'h5A5A_A5A5;
    @(posedge ipb_clk);
    @(negedge ipb_clk);
    model_rdata = 32'h5A5A_A5A5;
    chk("rst_restart_ack", {31'b0, ipb_ack}, 32'd1);
    chk("rst_restart_rdata", ipb_rdata, model_rdata);
    seg_rd_ack = '0;
    ipb_strobe = 1'b0;
    repeat (2) @(posedge ipb_clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
